// File: rtl/ft232h_sync_fifo_bfm.sv
// FT232H 245 synchronous FIFO bus-functional model: FPGA-side FIFO pins, AXI-stream PC side.
// Define FT232H_BFM_SIWU_EN to gate TX release on PKT_SIZE bytes or a send-immediate flush.
module ft232h_sync_fifo_bfm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16,
    parameter int unsigned PKT_SIZE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  txe_n,
    output logic                  rxf_n,
    input  logic                  wr_n,
    input  logic                  rd_n,
    input  logic                  oe_n,
    input  logic                  siwu_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic                  protocol_err
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_CW = $clog2(TX_DEPTH + 1);
    localparam int unsigned RX_CW = $clog2(RX_DEPTH + 1);

    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]      tx_wr_ptr;
    logic [TX_AW-1:0]      tx_rd_ptr;
    logic [TX_AW-1:0]      tx_rd_ptr_nxt;
    logic [TX_CW-1:0]      tx_cnt;
    logic [TX_CW-1:0]      tx_cnt_nxt;
    logic [DATA_WIDTH-1:0] tx_head_nxt;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_valid_nxt;

    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]      rx_wr_ptr;
    logic [RX_AW-1:0]      rx_rd_ptr;
    logic [RX_AW-1:0]      rx_rd_ptr_nxt;
    logic [RX_CW-1:0]      rx_cnt;
    logic [RX_CW-1:0]      rx_cnt_nxt;
    logic [DATA_WIDTH-1:0] rx_head_nxt;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rd_req;
    logic                  err_nxt;

    // TX bookkeeping; the head bypasses data_in when the written slot becomes the head
    always_comb begin
        tx_push       = ~wr_n & ~txe_n;
        tx_pop        = m_tvalid & m_tready;
        tx_rd_ptr_nxt = tx_pop ? tx_rd_ptr + TX_AW'(1) : tx_rd_ptr;
        tx_cnt_nxt    = tx_cnt + TX_CW'(tx_push) - TX_CW'(tx_pop);
        tx_head_nxt   = (tx_push && (tx_wr_ptr == tx_rd_ptr_nxt)) ? data_in
                                                                  : tx_mem[tx_rd_ptr_nxt];
    end

`ifdef FT232H_BFM_SIWU_EN
    logic flush_pending;
    logic flush_nxt;

    // Flush is armed by siwu_n and retires once the FIFO has fully drained
    always_comb begin
        flush_nxt = flush_pending;
        if (tx_cnt_nxt == '0) begin
            flush_nxt = 1'b0;
        end else if (!siwu_n) begin
            flush_nxt = 1'b1;
        end
        tx_valid_nxt = flush_nxt || (tx_cnt_nxt >= TX_CW'(PKT_SIZE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pending <= 1'b0;
        end else begin
            flush_pending <= flush_nxt;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg   = siwu_n | (PKT_SIZE == 0);
    assign tx_valid_nxt = (tx_cnt_nxt != '0);
`endif

    // RX bookkeeping; a read needs oe_n low at the previous edge, which data_oe records
    always_comb begin
        rd_req        = ~rd_n;
        rx_push       = s_tvalid & s_tready;
        rx_pop        = rd_req & ~rxf_n & data_oe;
        rx_rd_ptr_nxt = rx_pop ? rx_rd_ptr + RX_AW'(1) : rx_rd_ptr;
        rx_cnt_nxt    = rx_cnt + RX_CW'(rx_push) - RX_CW'(rx_pop);
        rx_head_nxt   = (rx_push && (rx_wr_ptr == rx_rd_ptr_nxt)) ? s_tdata
                                                                  : rx_mem[rx_rd_ptr_nxt];
        err_nxt       = protocol_err | (~wr_n & txe_n) | (rd_req & ~rx_pop);
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= data_in;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_cnt       <= '0;
            txe_n        <= 1'b1;
            m_tvalid     <= 1'b0;
            m_tdata      <= '0;
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_cnt       <= '0;
            rxf_n        <= 1'b1;
            s_tready     <= 1'b0;
            data_out     <= '0;
            data_oe      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            end
            tx_rd_ptr <= tx_rd_ptr_nxt;
            tx_cnt    <= tx_cnt_nxt;
            txe_n     <= (tx_cnt_nxt == TX_CW'(TX_DEPTH));
            m_tvalid  <= tx_valid_nxt;
            m_tdata   <= tx_head_nxt;

            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            end
            rx_rd_ptr <= rx_rd_ptr_nxt;
            rx_cnt    <= rx_cnt_nxt;
            rxf_n     <= (rx_cnt_nxt == '0);
            s_tready  <= (rx_cnt_nxt != RX_CW'(RX_DEPTH));
            if (rx_cnt_nxt != '0) begin
                data_out <= rx_head_nxt;
            end

            data_oe      <= ~oe_n;
            protocol_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ft232h_sync_fifo_bfm.sv
// Self-checking bench for ft232h_sync_fifo_bfm: directed steps plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_ft232h_sync_fifo_bfm;

    localparam int unsigned DW  = 8;
    localparam int unsigned TXD = 16;
    localparam int unsigned RXD = 16;
    localparam int unsigned PKT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          txe_n, rxf_n, wr_n, rd_n, oe_n, siwu_n;
    logic [DW-1:0] data_in, data_out, m_tdata, s_tdata;
    logic          data_oe, m_tvalid, m_tready, s_tvalid, s_tready, protocol_err;

    ft232h_sync_fifo_bfm #(
        .DATA_WIDTH(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .PKT_SIZE(PKT)
    ) dut (
        .clk(clk), .rst(rst), .txe_n(txe_n), .rxf_n(rxf_n), .wr_n(wr_n), .rd_n(rd_n),
        .oe_n(oe_n), .siwu_n(siwu_n), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model: byte queues plus the expected pin levels after each edge
    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    logic exp_txe_n, exp_rxf_n, exp_mtvalid, exp_stready, exp_oe, exp_err;
    bit   prev_oe_low;
    bit   flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("txe_n", 32'(txe_n), 32'(exp_txe_n));
        check("rxf_n", 32'(rxf_n), 32'(exp_rxf_n));
        check("m_tvalid", 32'(m_tvalid), 32'(exp_mtvalid));
        check("s_tready", 32'(s_tready), 32'(exp_stready));
        check("data_oe", 32'(data_oe), 32'(exp_oe));
        check("protocol_err", 32'(protocol_err), 32'(exp_err));
        if (exp_mtvalid && txq.size() > 0) check("m_tdata", 32'(m_tdata), 32'(txq[0]));
        if (rxq.size() > 0) check("data_out", 32'(data_out), 32'(rxq[0]));
        if (rst) check("data_out_rst", 32'(data_out), 32'h0);
    endtask

    // Apply the rules for one rising edge to the model, then advance the DUT and compare
    task automatic cycle();
        bit tx_pop, tx_push, rx_pop, rx_push;
        if (rst) begin
            txq.delete();
            rxq.delete();
            exp_txe_n   = 1'b1;
            exp_rxf_n   = 1'b1;
            exp_mtvalid = 1'b0;
            exp_stready = 1'b0;
            exp_oe      = 1'b0;
            exp_err     = 1'b0;
            prev_oe_low = 1'b0;
            flush       = 1'b0;
        end else begin
            tx_pop  = exp_mtvalid && m_tready;
            tx_push = !wr_n && !exp_txe_n;
            rx_pop  = !rd_n && !exp_rxf_n && prev_oe_low;
            rx_push = s_tvalid && exp_stready;
            if (!wr_n && exp_txe_n) exp_err = 1'b1;
            if (!rd_n && !rx_pop) exp_err = 1'b1;
            if (tx_pop) void'(txq.pop_front());
            if (tx_push) txq.push_back(data_in);
            if (rx_pop) void'(rxq.pop_front());
            if (rx_push) rxq.push_back(s_tdata);
            prev_oe_low = !oe_n;
            exp_oe      = !oe_n;
            exp_txe_n   = (txq.size() == TXD);
            exp_rxf_n   = (rxq.size() == 0);
            exp_stready = (rxq.size() < RXD);
`ifdef FT232H_BFM_SIWU_EN
            if (txq.size() == 0) flush = 1'b0;
            else if (!siwu_n) flush = 1'b1;
            exp_mtvalid = (txq.size() >= PKT) || flush;
`else
            exp_mtvalid = (txq.size() != 0);
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle();
        wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1; siwu_n = 1'b1;
        s_tvalid = 1'b0; m_tready = 1'b0; data_in = '0; s_tdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // Reset values, then first edge after release
        repeat (3) cycle();
        check("rst_txe_n", 32'(txe_n), 32'h1);
        check("rst_s_tready", 32'(s_tready), 32'h0);
        rst = 1'b0;
        cycle();
        check("post_rst_txe_n", 32'(txe_n), 32'h0);
        check("post_rst_s_tready", 32'(s_tready), 32'h1);

        // TX fill to full, overflow attempt, then in-order drain
        for (int i = 0; i < 16; i++) begin
            wr_n = 1'b0;
            data_in = 8'(8'h45 + i);
            cycle();
        end
        check("tx_full_txe_n", 32'(txe_n), 32'h1);
        data_in = 8'h55;
        cycle();
        wr_n = 1'b1;
        check("tx_overflow_err", 32'(protocol_err), 32'h1);
        m_tready = 1'b1;
        check("tx_head_first", 32'(m_tdata), 32'h45);
        repeat (16) cycle();
        check("tx_drained", 32'(m_tvalid), 32'h0);
        m_tready = 1'b0;

        // RX push and well-formed read
        do_reset();
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 8'(8'hA0 + i);
            cycle();
            if (i == 0) check("rx_first_rxf_n", 32'(rxf_n), 32'h0);
        end
        s_tvalid = 1'b0;
        oe_n = 1'b0;
        cycle();
        rd_n = 1'b0;
        repeat (3) cycle();
        rd_n = 1'b1;
        oe_n = 1'b1;
        check("rx_empty_rxf_n", 32'(rxf_n), 32'h1);
        check("rx_read_no_err", 32'(protocol_err), 32'h0);

        // Read without oe_n held low: rejected, flagged
        s_tvalid = 1'b1;
        s_tdata = 8'hB7;
        cycle();
        s_tvalid = 1'b0;
        cycle();
        rd_n = 1'b0;
        cycle();
        rd_n = 1'b1;
        check("rx_bad_rd_err", 32'(protocol_err), 32'h1);
        check("rx_bad_rd_data", 32'(data_out), 32'hB7);
        check("rx_bad_rd_rxf", 32'(rxf_n), 32'h0);

        // Wrap with concurrent push/pop every cycle in both directions
        do_reset();
        m_tready = 1'b1;
        oe_n = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            wr_n     = (i < 40) ? 1'b0 : 1'b1;
            data_in  = 8'($urandom);
            s_tvalid = (i < 40);
            s_tdata  = 8'($urandom);
            rd_n     = (i > 0) ? 1'b0 : 1'b1;
            cycle();
        end
        idle();
        check("wrap_tx_empty", 32'(m_tvalid), 32'h0);
        check("wrap_rx_empty", 32'(rxf_n), 32'h1);
        check("wrap_no_err", 32'(protocol_err), 32'h0);

        // Random traffic, including violations, against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            wr_n     = ($urandom_range(0, 1) == 0);
            data_in  = 8'($urandom);
            m_tready = ($urandom_range(0, 2) == 0);
            s_tvalid = ($urandom_range(0, 1) == 0);
            s_tdata  = 8'($urandom);
            oe_n     = ($urandom_range(0, 3) == 0);
            rd_n     = ($urandom_range(0, 1) == 0);
            siwu_n   = ($urandom_range(0, 15) != 0);
            cycle();
        end
        idle();

`ifdef FT232H_BFM_SIWU_EN
        // Packet gating and send-immediate flush
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_n = 1'b0;
            data_in = 8'(8'h10 + i);
            cycle();
        end
        wr_n = 1'b1;
        cycle();
        check("siwu_hold", 32'(m_tvalid), 32'h0);
        siwu_n = 1'b0;
        cycle();
        siwu_n = 1'b1;
        repeat (3) cycle();
        check("siwu_flushed", 32'(m_tvalid), 32'h0);
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_n = 1'b0;
            data_in = 8'(8'h20 + i);
            cycle();
        end
        wr_n = 1'b1;
        check("siwu_pkt_release", 32'(m_tvalid), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
